muldiv_seq: RTL
===============

# muldiv_seq

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair and feeds the ALU's `hi`/`lo` operands. It runs one iterative shift-add multiply or restoring divide at a time, holds `busy` so the PC/control logic stalls, and pulses `done` when HI/LO are committed. It also serves move-to-HI/LO writes from the control unit while idle.

## Interface
- `WIDTH`, default 32: operand width. HI/LO are each `WIDTH` bits.
- `clk` input, 1 bit: single clock. All state changes occur on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: single-cycle request. Sampled only in IDLE.
- `op` input, 2 bits: operation select. 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV. Sampled with `start`.
- `rs_val` input, WIDTH bits: multiplicand or dividend.
- `rt_val` input, WIDTH bits: multiplier or divisor.
- `wr_hi` input, 1 bit: move-to-HI strobe.
- `wr_lo` input, 1 bit: move-to-LO strobe.
- `wr_data` input, WIDTH bits: data for `wr_hi`/`wr_lo`.
- `flush` input, 1 bit: abort the in-flight operation.
- `busy` output, 1 bit: operation in progress. This is the stall request to the PC/control logic.
- `done` output, 1 bit: one-cycle pulse. HI/LO are valid in the same cycle.
- `div_zero` output, 1 bit: sticky flag set when the last DIV/DIVU had a zero divisor. Cleared by the next accepted `start`.
- `hi` output, WIDTH bits: HI register. Product upper half, or remainder.
- `lo` output, WIDTH bits: LO register. Product lower half, or quotient.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE + `start`:**
  - Latch `op`.
  - For signed ops, latch |rs| and |rt|, plus the result sign flags. The product/quotient sign is sign(rs) XOR sign(rt); the remainder sign is sign(rs).
  - Clear `div_zero`, load the 5-bit iteration counter with 0, go to RUN.
- **IDLE + divide op with rt_val = 0:** skip RUN and go straight to FIX with the zero flag set.
- **RUN, multiply:**
  - Each cycle: if the accumulator LSB is 1, add the multiplicand into the upper half (WIDTH+1-bit add including carry).
  - Then shift the 2·WIDTH accumulator right by 1.
- **RUN, divide:**
  - Each cycle: shift the {remainder, quotient} pair left by 1.
  - Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set quotient LSB = 1.
- **RUN exit:** after the counter reaches WIDTH-1 (32 iterations), go to FIX.
- **FIX, normal:**
  - Apply two's-complement negation per the sign flags. For a signed multiply, negate the whole 2·WIDTH product.
  - Write HI/LO, pulse `done`, return to IDLE.
- **FIX, zero divisor:** HI = rs_val (as latched), LO = all ones, `div_zero` = 1, pulse `done`.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural wrap). No flag is raised.
- **Move-to-HI/LO:** `wr_hi`/`wr_lo` write `wr_data` only in IDLE. Both may be asserted in the same cycle. They are ignored while `busy`.
- **`start` and `wr_*` in the same IDLE cycle:** `start` wins and the write is dropped.
- **`start` while `busy`:** ignored. No queueing.
- **`flush` in RUN or FIX:** return to IDLE next edge. HI/LO stay unchanged, no `done`, `div_zero` unchanged. `flush` in IDLE has no effect, and it takes priority over `start`.
- **`rst`:** overrides everything, including mid-operation. The operation is discarded.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0. State = IDLE, counter = 0.
- `start` sampled at edge E0. `busy` = 1 from E0 through E33, i.e. 33 cycles.
- RUN covers edges E1..E32. FIX is the cycle after E32.
- At edge E33: HI/LO updated, `done` = 1 for exactly one cycle, `busy` = 0 in that same cycle.
- Zero-divisor path: `busy` = 1 for one cycle (E0..E1). `done`, HI/LO and `div_zero` appear after E1.
- The earliest new `start` accepted is at E33 (the `done` cycle, since the block is IDLE). Back-to-back throughput is one op per 33 cycles.
- `wr_hi`/`wr_lo` take effect on the next edge. `hi`/`lo` are registered outputs and do not combinationally bypass `wr_data`.
- `busy`, `done` and `div_zero` are registered and carry no combinational path from the inputs.

## Test plan
- **MULTU:** rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> after 33 busy cycles, `done` pulse, HI = 0xFFFFFFFE, LO = 0x00000001.
- **MULT, then DIV back-to-back:**
  - MULT rs = 0xFFFFFFFD (-3), rt = 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - Then DIV rs = 0xFFFFFFF9 (-7), rt = 2, with `start` on the `done` cycle -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **DIVU by zero:** rs = 7, rt = 0 -> `done` two edges after `start`, HI = 7, LO = 0xFFFFFFFF, `div_zero` = 1. The next `start` clears `div_zero`.
- **Flush and dropped start:**
  - `flush` at the 10th RUN cycle of MULTU 3×4 with HI/LO preloaded 0x11/0x22 -> no `done`, HI = 0x11, LO = 0x22, `busy` = 0 next cycle.
  - A `start` asserted during RUN is ignored.
- **Move-to-HI/LO and reset:**
  - `wr_hi` with 0xDEADBEEF while busy -> HI is unchanged after `done`.
  - `wr_lo` in IDLE -> LO updated next edge.
  - `start` plus `wr_hi` in the same cycle -> HI gets the op result, not `wr_data`.
  - `rst` mid-RUN -> all outputs return to their reset values next edge.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0, `div_zero` = 0.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Handshake/bus bundle between the control unit and the multiply/divide sequencer.
//   master : control side, drives start/op/operands, move-to-HI/LO strobes and flush.
//   slave  : sequencer side, returns busy/done/div_zero and the HI/LO registers.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;        // 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data, flush,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, wr_hi, wr_lo, wr_data, flush,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
// Runs one iterative shift-add multiply or restoring divide (WIDTH iterations),
// holds busy while running and pulses done when HI/LO are committed.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : muldiv_seq_if slave (start/op/operands, wr_hi/wr_lo/wr_data, flush,
//              busy/done/div_zero, hi/lo)
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    muldiv_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q;
    logic               is_div_q;
    logic [CntW-1:0]    cnt_q;
    // Multiply: {product hi, multiplier/product lo}. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
    logic               neg_lo_q;  // negate product / quotient
    logic               neg_hi_q;  // negate remainder
    logic               zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, div_zero_q;

    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        rs_neg = bus.op[0] & bus.rs_val[WIDTH-1];
        rt_neg = bus.op[0] & bus.rt_val[WIDTH-1];
        rs_abs = rs_neg ? -bus.rs_val : bus.rs_val;
        rt_abs = rt_neg ? -bus.rt_val : bus.rt_val;

        // Shift-add: carry out of the upper-half add is shifted back in.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: shifted remainder needs WIDTH+1 bits for the compare.
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        rem_sub = rem_sh[WIDTH-1:0] - opnd_q;
        if (rem_sh >= {1'b0, opnd_q}) begin
            div_next = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            is_div_q   <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            zero_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // flush blocks a simultaneous start; start drops any wr_hi/wr_lo.
                    if (bus.start && !bus.flush) begin
                        is_div_q   <= bus.op[1];
                        cnt_q      <= '0;
                        div_zero_q <= 1'b0;
                        busy_q     <= 1'b1;
                        neg_lo_q   <= rs_neg ^ rt_neg;
                        neg_hi_q   <= rs_neg;
                        if (bus.op[1] && bus.rt_val == '0) begin
                            zero_q  <= 1'b1;
                            acc_q   <= {{WIDTH{1'b0}}, bus.rs_val};  // raw dividend -> HI
                            opnd_q  <= '0;
                            state_q <= StFix;
                        end else begin
                            zero_q  <= 1'b0;
                            state_q <= StRun;
                            if (bus.op[1]) begin
                                acc_q  <= {{WIDTH{1'b0}}, rs_abs};
                                opnd_q <= rt_abs;
                            end else begin
                                acc_q  <= {{WIDTH{1'b0}}, rt_abs};
                                opnd_q <= rs_abs;
                            end
                        end
                    end else begin
                        if (bus.wr_hi) hi_q <= bus.wr_data;
                        if (bus.wr_lo) lo_q <= bus.wr_data;
                    end
                end
                StRun: begin
                    if (bus.flush) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (zero_q) begin
                            hi_q       <= acc_q[WIDTH-1:0];
                            lo_q       <= '1;
                            div_zero_q <= 1'b1;
                        end else if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
